// File: rtl/aes_round_sequencer_if.sv
// Handshake bundle for aes_round_sequencer: plaintext/key in, ciphertext out, status.
interface aes_round_sequencer_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] pt_in;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ct_out;
   logic         busy;
   logic [3:0]   round_idx;

   modport master (
      output in_valid, pt_in, key_in, out_ready,
      input  in_ready, out_valid, ct_out, busy, round_idx
   );

   modport slave (
      input  in_valid, pt_in, key_in, out_ready,
      output in_ready, out_valid, ct_out, busy, round_idx
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one full round per clock, round keys expanded on the fly.
module aes_round_sequencer #(
   parameter int unsigned ROUNDS = 10
) (
   input logic                  clk,
   input logic                  reset,
   aes_round_sequencer_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;
   typedef logic [15:0][7:0] blk_t;

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   // Element 255 holds sbox(0x00), so the lookup index is the inverted input byte.
   localparam logic [255:0][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[~b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_e       state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [127:0] rk_q, rk_d;
   logic [127:0] ct_q, ct_d;
   logic [3:0]   round_q, round_d;
   logic         out_valid_q, out_valid_d;
   logic         in_ready_q, in_ready_d;
   logic         busy_q, busy_d;

   blk_t         st_b, sr_b, mc_b;
   logic [31:0]  w0, w1, w2, w3, sub_rot;
   logic [127:0] rk_next, round_out;

   // Key schedule step: SubWord(RotWord(w3)) ^ rcon folds into w0, then ripples through.
   assign {w0, w1, w2, w3} = rk_q;
   assign sub_rot = {sbox(w3[23:16]) ^ rcon(round_q), sbox(w3[15:8]),
                     sbox(w3[7:0]), sbox(w3[31:24])};
   assign rk_next[127:96] = w0 ^ sub_rot;
   assign rk_next[95:64]  = w1 ^ rk_next[127:96];
   assign rk_next[63:32]  = w2 ^ rk_next[95:64];
   assign rk_next[31:0]   = w3 ^ rk_next[63:32];

   // Byte i of the block lives at element 15-i; column c holds bytes 4c..4c+3.
   assign st_b = st_q;
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr_b[15-(4*c+r)] = sbox(st_b[15-(4*((c+r)%4)+r)]);
      end
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_b[15-4*c];
      assign a1 = sr_b[14-4*c];
      assign a2 = sr_b[13-4*c];
      assign a3 = sr_b[12-4*c];
      assign mc_b[15-4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc_b[14-4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc_b[13-4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc_b[12-4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

   assign round_out = ((round_q == LAST_ROUND) ? 128'(sr_b) : 128'(mc_b)) ^ rk_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         st_q        <= '0;
         rk_q        <= '0;
         ct_q        <= '0;
         round_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         rk_q        <= rk_d;
         ct_q        <= ct_d;
         round_q     <= round_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      rk_d        = rk_q;
      ct_d        = ct_q;
      round_d     = round_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               st_d    = bus.pt_in ^ bus.key_in;
               rk_d    = bus.key_in;
               round_d = 4'd1;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            rk_d = rk_next;
            st_d = round_out;
            if (round_q == LAST_ROUND) begin
               ct_d        = round_out;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               round_d     = 4'd0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Status flags are registered copies of the upcoming state.
      in_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ct_out    = ct_q;
   assign bus.busy      = busy_q;
   assign bus.round_idx = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer using FIPS-197 vectors and hand-derived timing.
module tb_aes_round_sequencer;

   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   // C.1 vector after a single final round: ShiftRows(SubBytes(pt^key)) ^ round-1 key.
   localparam logic [127:0] R1_CT  = 128'hb5f99471dbcf93fe17d6cfa06c61a619;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   aes_round_sequencer_if bus ();
   aes_round_sequencer_if bus1 ();

   aes_round_sequencer #(.ROUNDS(10)) dut (.clk(clk), .reset(reset), .bus(bus));
   aes_round_sequencer #(.ROUNDS(1))  dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [127:0] pt, input logic [127:0] key);
      @(negedge clk);
      bus.pt_in    = pt;
      bus.key_in   = key;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                  bus.in_ready, bus.out_valid, bus.busy);
      end
      n_checks++;
      if (bus.round_idx !== 4'd0 || bus.ct_out !== 128'h0) begin
         n_errors++;
         $display("FAIL reset_data: round_idx=%0d ct=%h, want 0 and zero", bus.round_idx, bus.ct_out);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL post_reset: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_fips_c1();
      int cyc;
      send(C1_PT, C1_KEY);
      wait_out(cyc);
      n_checks++;
      if (cyc !== 10) begin
         n_errors++;
         $display("FAIL c1_latency: got %0d cycles, want 10", cyc);
      end
      n_checks++;
      if (bus.ct_out !== C1_CT) begin
         n_errors++;
         $display("FAIL c1_ct: got %h want %h", bus.ct_out, C1_CT);
      end
      consume();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.round_idx !== 4'd0) begin
         n_errors++;
         $display("FAIL c1_release: out_valid=%b in_ready=%b round_idx=%0d, want 0 1 0",
                  bus.out_valid, bus.in_ready, bus.round_idx);
      end
   endtask

   task automatic test_fips_b();
      send(B_PT, B_KEY);
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if (bus.round_idx !== 4'(k + 1) || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b_round_step: cycle %0d round_idx=%0d out_valid=%b busy=%b, want %0d 0 1",
                     k, bus.round_idx, bus.out_valid, bus.busy, k + 1);
         end
         @(negedge clk);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.ct_out !== B_CT || bus.round_idx !== 4'd10) begin
         n_errors++;
         $display("FAIL b_result: out_valid=%b ct=%h round_idx=%0d, want 1 %h 10",
                  bus.out_valid, bus.ct_out, bus.round_idx, B_CT);
      end
      consume();
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.round_idx !== 4'd0 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL b_release: in_ready=%b round_idx=%0d busy=%b, want 1 0 0",
                  bus.in_ready, bus.round_idx, bus.busy);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      send(C1_PT, C1_KEY);
      wait_out(cyc);
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.ct_out !== C1_CT || bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_hold: cycle %0d out_valid=%b ct=%h in_ready=%b, want 1 %h 0",
                     i, bus.out_valid, bus.ct_out, bus.in_ready, C1_CT);
         end
         @(negedge clk);
      end
      consume();
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_busy_ignore();
      send(B_PT, B_KEY);
      for (int i = 0; i < 14; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.pt_in    = {4{$urandom()}};
         bus.key_in   = {4{$urandom()}};
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.ct_out !== B_CT || bus.round_idx !== 4'd10) begin
         n_errors++;
         $display("FAIL busy_ignore: out_valid=%b ct=%h round_idx=%0d, want 1 %h 10",
                  bus.out_valid, bus.ct_out, bus.round_idx, B_CT);
      end
      consume();
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL busy_release: in_ready=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      send(B_PT, B_KEY);
      repeat (4) @(negedge clk);
      n_checks++;
      if (bus.round_idx !== 4'd5) begin
         n_errors++;
         $display("FAIL mid_round_idx: got %0d want 5", bus.round_idx);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.round_idx !== 4'd0 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_round_reset: out_valid=%b in_ready=%b round_idx=%0d busy=%b, want 0 1 0 0",
                  bus.out_valid, bus.in_ready, bus.round_idx, bus.busy);
      end
      @(negedge clk);
      reset = 1'b0;
      send(C1_PT, C1_KEY);
      wait_out(cyc);
      n_checks++;
      if (cyc !== 10 || bus.ct_out !== C1_CT) begin
         n_errors++;
         $display("FAIL rerun_c1: latency %0d ct=%h, want 10 %h", cyc, bus.ct_out, C1_CT);
      end
      // Reset while holding a result in DONE must drop out_valid without a clock edge.
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.round_idx !== 4'd0) begin
         n_errors++;
         $display("FAIL done_reset: out_valid=%b in_ready=%b round_idx=%0d, want 0 1 0",
                  bus.out_valid, bus.in_ready, bus.round_idx);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [127:0] vpt [2];
      logic [127:0] vkey [2];
      logic [127:0] vct [2];
      int acc [2];
      int outt [2];
      int cyc;
      int n_acc;
      int n_out;
      vpt[0] = C1_PT; vkey[0] = C1_KEY; vct[0] = C1_CT;
      vpt[1] = B_PT;  vkey[1] = B_KEY;  vct[1] = B_CT;
      acc[0] = 0; acc[1] = 0; outt[0] = 0; outt[1] = 0;
      cyc = 0; n_acc = 0; n_out = 0;
      bus.out_ready = 1'b1;
      while (n_out < 2 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (n_acc < 2) begin
            bus.pt_in    = vpt[n_acc];
            bus.key_in   = vkey[n_acc];
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bus.in_ready && bus.in_valid) begin
            acc[n_acc] = cyc;
            n_acc++;
         end
         if (bus.out_valid) begin
            n_checks++;
            if (bus.ct_out !== vct[n_out]) begin
               n_errors++;
               $display("FAIL b2b_ct%0d: got %h want %h", n_out, bus.ct_out, vct[n_out]);
            end
            outt[n_out] = cyc;
            n_out++;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      n_checks++;
      if (n_out !== 2 || n_acc !== 2) begin
         n_errors++;
         $display("FAIL b2b_count: accepted %0d produced %0d, want 2 2", n_acc, n_out);
      end
      n_checks++;
      if (acc[1] - acc[0] !== 12) begin
         n_errors++;
         $display("FAIL b2b_spacing: accept spacing %0d, want 12", acc[1] - acc[0]);
      end
      n_checks++;
      if (outt[0] - acc[0] !== 11) begin
         n_errors++;
         $display("FAIL b2b_latency: first output %0d samples after accept, want 11", outt[0] - acc[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_one_round();
      int cyc;
      @(negedge clk);
      bus1.pt_in    = C1_PT;
      bus1.key_in   = C1_KEY;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      cyc = 0;
      while (!bus1.out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc !== 1 || bus1.ct_out !== R1_CT) begin
         n_errors++;
         $display("FAIL one_round: latency %0d ct=%h, want 1 %h", cyc, bus1.ct_out, R1_CT);
      end
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      n_checks++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL one_round_release: in_ready=%b out_valid=%b, want 1 0",
                  bus1.in_ready, bus1.out_valid);
      end
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.pt_in      = '0;
      bus.key_in     = '0;
      bus.out_ready  = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.pt_in     = '0;
      bus1.key_in    = '0;
      bus1.out_ready = 1'b0;
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_one_round();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
